hazard_forwarding_unit: RTL

Pipeline control block for the RISC-V PPU that closes the loop on the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It watches the destination and enable fields those registers carry forward and drives their control inputs back: load enables, conditional and unconditional flushes, NOP insertion and the ID-stage operand-forwarding selects. It holds a load-use stall FSM with a configurable stall length and saturating stall and flush event counters for bring-up.

---
 rtl/ppu_hazard_pkg.sv | 39 +++
 rtl/forwarding_select.sv | 44 ++++
 rtl/hazard_forwarding_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ppu_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppu_hazard_pkg
// Purpose  : Shared encodings and helpers for the PPU hazard/forwarding
//            control block: forwarding mux selects, hazard FSM states and
//            the register-match predicate used by both forwarding and
//            load-use detection.
// Revision : 1.0 - initial release
// ============================================================================
package ppu_hazard_pkg;

    // Operand mux selects for the ID-stage PA/PB forwarding multiplexers
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Load-use stall FSM encoding
    localparam int         HZ_STATE_W = 1;
    localparam logic [0:0] RUN        = 1'b0;
    localparam logic [0:0] STALL      = 1'b1;

    // Architectural register index width (x0..x31)
    localparam int REG_W = 5;

    // A later stage can supply a source operand only when the ID instruction
    // really reads that source, the stage really writes the register file,
    // and the destination is not x0 (x0 writes are discarded).
    function automatic logic reg_match(
        input logic             uses,
        input logic             rf_enable,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src
    );
        return uses && rf_enable && (rd != '0) && (rd == src);
    endfunction

endpackage : ppu_hazard_pkg
`default_nettype wire

// File: rtl/forwarding_select.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_select
// Purpose  : Combinational forwarding select for one ID-stage source operand.
//            Picks the youngest in-flight producer (EX > MEM > WB), falling
//            back to the register file when no stage matches.
// Revision : 1.0 - initial release
// ============================================================================
module forwarding_select
    import ppu_hazard_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             uses,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_enable,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rf_enable,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rf_enable,
    output logic [1:0]       sel
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = reg_match(uses, ex_rf_enable,  ex_rd,  src);
    assign hit_mem = reg_match(uses, mem_rf_enable, mem_rd, src);
    assign hit_wb  = reg_match(uses, wb_rf_enable,  wb_rd,  src);

    // Youngest producer wins so the operand sees the most recent write
    always_comb begin
        sel = FWD_RF;
        if (hit_ex) begin
            sel = FWD_EX;
        end else if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end

endmodule : forwarding_select
`default_nettype wire

// File: rtl/hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forwarding_unit
// Purpose  : Pipeline control for the PPU stage registers. Produces operand
//            forwarding selects, load-use stalls (LOAD_LAT cycles long),
//            branch/JAL flushes and saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forwarding_unit
    import ppu_hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_RS1,
    input  logic [REG_W-1:0] ID_RS2,
    input  logic             ID_Uses_RS1,
    input  logic             ID_Uses_RS2,
    input  logic             ID_JAL_Instr,
    input  logic [REG_W-1:0] EX_RD,
    input  logic             EX_RF_Enable,
    input  logic             EX_Load_Instr,
    input  logic [REG_W-1:0] MEM_RD,
    input  logic             MEM_RF_Enable,
    input  logic [REG_W-1:0] WB_RD,
    input  logic             WB_RF_Enable,
    input  logic             Branch_Taken,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             ID_EX_Nop,
    output logic             IF_ID_Cond_Flush,
    output logic             IF_ID_Uncond_Flush,
    output logic             ID_EX_Cond_Flush,
    output logic [1:0]       Fwd_A_Sel,
    output logic [1:0]       Fwd_B_Sel,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    // Cycles still to be stalled after the detection cycle
    localparam int               REM_W      = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [REM_W-1:0] REM_RELOAD = REM_W'(LOAD_LAT - 1);

    logic [HZ_STATE_W-1:0] state;
    logic [HZ_STATE_W-1:0] state_next;
    logic [REM_W-1:0]      remaining;
    logic [REM_W-1:0]      remaining_next;

    logic [1:0] sel_a_raw;
    logic [1:0] sel_b_raw;
    logic       load_use;
    logic       stall_active;
    logic       flush_any;

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    forwarding_select u_fwd_a (
        .src           (ID_RS1),
        .uses          (ID_Uses_RS1),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_Enable),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_Enable),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_Enable),
        .sel           (sel_a_raw)
    );

    forwarding_select u_fwd_b (
        .src           (ID_RS2),
        .uses          (ID_Uses_RS2),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_Enable),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_Enable),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_Enable),
        .sel           (sel_b_raw)
    );

    // A load in EX cannot forward its data yet; the dependent ID
    // instruction must wait until the load reaches MEM.
    assign load_use = EX_Load_Instr &&
                      (reg_match(ID_Uses_RS1, EX_RF_Enable, EX_RD, ID_RS1) ||
                       reg_match(ID_Uses_RS2, EX_RF_Enable, EX_RD, ID_RS2));

    // ------------------------------------------------------------------
    // Load-use stall FSM
    // ------------------------------------------------------------------

    // State register: reset aborts any stall in progress
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= RUN;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // Next state: a taken branch discards the stalled instruction, so it
    // always returns the FSM to RUN
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        if (Branch_Taken) begin
            state_next     = RUN;
            remaining_next = '0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use && (LOAD_LAT > 1)) begin
                        state_next     = STALL;
                        remaining_next = REM_RELOAD;
                    end
                end
                STALL: begin
                    if (remaining <= REM_W'(1)) begin
                        state_next     = RUN;
                        remaining_next = '0;
                    end else begin
                        remaining_next = remaining - REM_W'(1);
                    end
                end
                default: begin
                    state_next     = RUN;
                    remaining_next = '0;
                end
            endcase
        end
    end

    // Outputs: stall/flush controls, all forced idle while in reset
    always_comb begin
        stall_active = 1'b0;
        if (!Reset && !Branch_Taken) begin
            stall_active = (state == STALL) || ((state == RUN) && load_use);
        end

        PC_LE              = !stall_active;
        IF_ID_LE           = !stall_active;
        ID_EX_Nop          = stall_active;
        IF_ID_Cond_Flush   = !Reset && Branch_Taken;
        ID_EX_Cond_Flush   = !Reset && Branch_Taken;
        // A JAL held in ID by a stall keeps its redirect until it is released
        IF_ID_Uncond_Flush = !Reset && ID_JAL_Instr && !stall_active;
        Fwd_A_Sel          = Reset ? FWD_RF : sel_a_raw;
        Fwd_B_Sel          = Reset ? FWD_RF : sel_b_raw;
    end

    assign flush_any = IF_ID_Cond_Flush || IF_ID_Uncond_Flush || ID_EX_Cond_Flush;

    // ------------------------------------------------------------------
    // Saturating bring-up event counters
    // ------------------------------------------------------------------

    // Stall counter: one count per cycle the PC is held
    always_ff @(posedge clk) begin
        if (Reset) begin
            Stall_Count <= '0;
        end else if (!PC_LE && (Stall_Count != '1)) begin
            Stall_Count <= Stall_Count + CNT_W'(1);
        end
    end

    // Flush counter: one count per cycle with any flush asserted
    always_ff @(posedge clk) begin
        if (Reset) begin
            Flush_Count <= '0;
        end else if (flush_any && (Flush_Count != '1)) begin
            Flush_Count <= Flush_Count + CNT_W'(1);
        end
    end

endmodule : hazard_forwarding_unit
`default_nettype wire
